i2c_reg_writer: RTL and testbench

Single-register I2C write master. The HDMI init sequencer drives it with one (device, register, data) triple per transaction. It serialises START, device byte, register byte, data byte and STOP onto open-drain SCL/SDA toward the HDMI transmitter. It exposes a ready/start handshake, a done pulse and a sticky NACK flag.

---
 rtl/i2c_pkg.sv | 24 ++
 rtl/i2c_quarter_tick.sv | 38 +++
 rtl/i2c_reg_writer.sv | 194 +++++++++++++++++++
 tb/tb_i2c_reg_writer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_pkg
//  Description : Shared types and framing constants for the single-register
//                I2C write master.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BITS  = 3'd2,
        ST_ACK   = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    localparam int QUARTERS_PER_BIT = 4;
    localparam int BITS_PER_BYTE    = 9;   // 8 data bits + ACK slot
    localparam int BYTES_PER_XFER   = 3;   // device, register, data
    localparam int XFER_QUARTERS    = 116; // START + 3 bytes + STOP

endpackage
`default_nettype wire

// File: rtl/i2c_quarter_tick.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_quarter_tick
//  Description : Quarter-SCL-period divider. Counts 0..QUARTER_DIV-1 while
//                running, pulses o_tick on the wrap, freezes while i_hold is
//                set (clock stretching) and restarts from 0 on i_clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_quarter_tick #(
    parameter int QUARTER_DIV = 125
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_run,
    input  logic i_hold,
    output logic o_tick
);

    localparam logic [15:0] C_LAST = 16'(QUARTER_DIV - 1);

    logic [15:0] r_count;

    assign o_tick = i_run && !i_hold && (r_count == C_LAST);

    // Divider: idle at zero, free-running only while a transfer is active.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear || !i_run || o_tick) begin
            r_count <= '0;
        end else if (!i_hold) begin
            r_count <= r_count + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_reg_writer.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_reg_writer
//  Description : Single-register I2C write master. Sends START, device byte
//                (R/W forced to write), register byte, data byte and STOP on
//                open-drain SCL/SDA. Reports completion with a done pulse and
//                a sticky NACK flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_reg_writer
    import i2c_pkg::*;
#(
    parameter int QUARTER_DIV = 125,
    parameter bit STRETCH_EN  = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] data,
    output logic       ready,
    output logic       done,
    output logic       ack_err,
    output logic       sda_oe,
    input  logic       sda_i,
    output logic       scl_oe,
    input  logic       scl_i
);

    localparam logic [1:0] C_LAST_Q    = 2'(QUARTERS_PER_BIT - 1);
    localparam logic [1:0] C_SAMPLE_Q  = 2'd2;
    localparam logic [2:0] C_MSB_BIT   = 3'(BITS_PER_BYTE - 2);
    localparam logic [1:0] C_LAST_BYTE = 2'(BYTES_PER_XFER - 1);

    state_t     r_state,      w_state_nxt;
    logic [1:0] r_q,          w_q_nxt;
    logic [1:0] r_byte_idx,   w_byte_idx_nxt;
    logic [2:0] r_bit_idx,    w_bit_idx_nxt;
    logic       r_ack_sample, w_ack_sample_nxt;
    logic       r_ack_err,    w_ack_err_nxt;
    logic       r_done,       w_done_nxt;
    logic [7:0] r_dev, r_reg, r_data;

    logic       w_accept;
    logic       w_tick;
    logic       w_hold;
    logic       w_bit;
    logic [7:0] w_cur_byte;

    assign ready   = (r_state == ST_IDLE);
    assign done    = r_done;
    assign ack_err = r_ack_err;

    // The done cycle itself never accepts, so a held start restarts one cycle later.
    assign w_accept = start && ready && !r_done;

    // Slave stretching only matters while SCL is released during a bit or ACK slot.
    assign w_hold = STRETCH_EN && ((r_state == ST_BITS) || (r_state == ST_ACK)) &&
                    r_q[1] && !scl_oe && !scl_i;

    i2c_quarter_tick #(
        .QUARTER_DIV (QUARTER_DIV)
    ) u_quarter_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clear (w_accept),
        .i_run   (r_state != ST_IDLE),
        .i_hold  (w_hold),
        .o_tick  (w_tick)
    );

    // Select the byte in flight and the bit currently on the wire (MSB first).
    always_comb begin
        case (r_byte_idx)
            2'd0:    w_cur_byte = r_dev;
            2'd1:    w_cur_byte = r_reg;
            default: w_cur_byte = r_data;
        endcase
        w_bit = w_cur_byte[r_bit_idx];
    end

    // Pad drive per state and quarter; SDA only changes while SCL is low.
    always_comb begin
        sda_oe = 1'b0;
        scl_oe = 1'b0;
        case (r_state)
            ST_START: begin
                sda_oe = (r_q != 2'd0);
                scl_oe = (r_q == C_LAST_Q);
            end
            ST_BITS: begin
                sda_oe = ~w_bit;
                scl_oe = ~r_q[1];
            end
            ST_ACK: begin
                sda_oe = 1'b0;
                scl_oe = ~r_q[1];
            end
            ST_STOP: begin
                sda_oe = ~r_q[1];
                scl_oe = (r_q == 2'd0);
            end
            default: begin
                sda_oe = 1'b0;
                scl_oe = 1'b0;
            end
        endcase
    end

    // Next-state logic: accept a request, then step one quarter per tick.
    always_comb begin
        w_state_nxt      = r_state;
        w_q_nxt          = r_q;
        w_byte_idx_nxt   = r_byte_idx;
        w_bit_idx_nxt    = r_bit_idx;
        w_ack_sample_nxt = r_ack_sample;
        w_ack_err_nxt    = r_ack_err;
        w_done_nxt       = 1'b0;
        if (w_accept) begin
            w_state_nxt    = ST_START;
            w_q_nxt        = 2'd0;
            w_byte_idx_nxt = 2'd0;
            w_bit_idx_nxt  = C_MSB_BIT;
            w_ack_err_nxt  = 1'b0;
        end else if (w_tick) begin
            w_q_nxt = r_q + 2'd1;
            case (r_state)
                ST_START: begin
                    if (r_q == C_LAST_Q) w_state_nxt = ST_BITS;
                end
                ST_BITS: begin
                    if (r_q == C_LAST_Q) begin
                        if (r_bit_idx == 3'd0) w_state_nxt = ST_ACK;
                        else                   w_bit_idx_nxt = r_bit_idx - 3'd1;
                    end
                end
                ST_ACK: begin
                    if (r_q == C_SAMPLE_Q) w_ack_sample_nxt = sda_i;
                    if (r_q == C_LAST_Q) begin
                        if (r_ack_sample) begin
                            w_ack_err_nxt = 1'b1;
                            w_state_nxt   = ST_STOP;
                        end else if (r_byte_idx == C_LAST_BYTE) begin
                            w_state_nxt = ST_STOP;
                        end else begin
                            w_byte_idx_nxt = r_byte_idx + 2'd1;
                            w_bit_idx_nxt  = C_MSB_BIT;
                            w_state_nxt    = ST_BITS;
                        end
                    end
                end
                ST_STOP: begin
                    if (r_q == C_LAST_Q) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers; reset releases the bus without a STOP.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_q          <= 2'd0;
            r_byte_idx   <= 2'd0;
            r_bit_idx    <= 3'd0;
            r_ack_sample <= 1'b0;
            r_ack_err    <= 1'b0;
            r_done       <= 1'b0;
            r_dev        <= 8'd0;
            r_reg        <= 8'd0;
            r_data       <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_q          <= w_q_nxt;
            r_byte_idx   <= w_byte_idx_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_ack_sample <= w_ack_sample_nxt;
            r_ack_err    <= w_ack_err_nxt;
            r_done       <= w_done_nxt;
            if (w_accept) begin
                r_dev  <= dev_addr & 8'hFE;
                r_reg  <= reg_addr;
                r_data <= data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_reg_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_reg_writer
//  Description : Self-checking bench for i2c_reg_writer with a bus-level
//                slave model (ACK/NACK, clock stretching) and a transaction
//                reference model for bytes, latency and status.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_reg_writer;

    localparam int QD          = 2;
    localparam int C_SUCCESS_Q = 4 + 3 * 36 + 4;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic       start    = 1'b0;
    logic [7:0] dev_addr = 8'd0;
    logic [7:0] reg_addr = 8'd0;
    logic [7:0] data     = 8'd0;
    logic       ready, done, ack_err, sda_oe, scl_oe;
    logic       sda_i, scl_i;

    logic       sl_pull     = 1'b0;
    int         stretch_cnt = 0;

    assign sda_i = ~sda_oe & ~sl_pull;
    assign scl_i = ~scl_oe & (stretch_cnt == 0);

    i2c_reg_writer #(
        .QUARTER_DIV (QD),
        .STRETCH_EN  (1'b1)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .dev_addr (dev_addr),
        .reg_addr (reg_addr),
        .data     (data),
        .ready    (ready),
        .done     (done),
        .ack_err  (ack_err),
        .sda_oe   (sda_oe),
        .sda_i    (sda_i),
        .scl_oe   (scl_oe),
        .scl_i    (scl_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Slave configuration (written by stimulus) and observations (written by the monitor).
    int         cfg_nack    = 3;
    int         cfg_st_byte = -1;
    int         cfg_st_bit  = -1;
    int         cfg_st_len  = 0;
    logic [7:0] rx_q[$];
    int         n_starts = 0;
    int         n_stops  = 0;

    // Bus-level slave: decodes START/STOP and bytes, drives ACK, stretches SCL.
    initial begin : bus_monitor
        logic       prev_scl, prev_sda, prev_scl_oe, l_scl, l_sda, st_used;
        logic [7:0] shreg;
        int         bitcnt, byte_no;
        prev_scl = 1'b1; prev_sda = 1'b1; prev_scl_oe = 1'b0; st_used = 1'b0;
        shreg = 8'd0; bitcnt = 0; byte_no = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                sl_pull = 1'b0; stretch_cnt = 0; bitcnt = 0; byte_no = 0;
            end else begin
                if (stretch_cnt > 0) stretch_cnt--;
                if (prev_scl_oe && !scl_oe && !st_used &&
                    byte_no == cfg_st_byte && bitcnt == cfg_st_bit) begin
                    stretch_cnt = cfg_st_len;
                    st_used     = 1'b1;
                end
                l_scl = !scl_oe && (stretch_cnt == 0);
                l_sda = !sda_oe && !sl_pull;
                if (prev_scl && l_scl && prev_sda && !l_sda) begin
                    n_starts++; bitcnt = 0; byte_no = 0; st_used = 1'b0; rx_q.delete();
                end
                if (prev_scl && l_scl && !prev_sda && l_sda) n_stops++;
                if (!prev_scl && l_scl) begin
                    if (bitcnt < 8) begin
                        shreg = {shreg[6:0], l_sda};
                        bitcnt++;
                        if (bitcnt == 8) rx_q.push_back(shreg);
                    end else begin
                        bitcnt = 9;
                    end
                end
                if (prev_scl && !l_scl) begin
                    if (bitcnt == 8 && byte_no != cfg_nack) begin
                        sl_pull = 1'b1;
                    end else if (bitcnt == 9) begin
                        sl_pull = 1'b0; bitcnt = 0; byte_no++;
                    end
                end
            end
            prev_scl    = !scl_oe && (stretch_cnt == 0);
            prev_sda    = !sda_oe && !sl_pull;
            prev_scl_oe = scl_oe;
        end
    end

    task automatic wait_done(output int waited);
        waited = 0;
        while (done !== 1'b1 && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        check("done_seen", done, 1);
    endtask

    // One transaction against the reference model. nack: byte index that is NACKed, 3 = none.
    // stb/stbit/stlen: stretch byte, bits already received in that byte, stretch length.
    task automatic run_xfer(input logic [7:0] d, input logic [7:0] r, input logic [7:0] x,
                            input int nack, input int stb, input int stbit, input int stlen,
                            input bit hold);
        logic [7:0] exp_b[3];
        int nb, quarters, exp_lat, t0, w, s0, p0;
        exp_b[0] = d & 8'hFE; exp_b[1] = r; exp_b[2] = x;
        nb       = (nack < 3) ? nack + 1 : 3;
        quarters = (nack < 3) ? 4 + 36 * (nack + 1) + 4 : C_SUCCESS_Q;
        exp_lat  = 1 + quarters * QD + ((stb >= 0 && stb < nb) ? stlen : 0);
        cfg_nack = nack; cfg_st_byte = stb; cfg_st_bit = stbit; cfg_st_len = stlen;
        @(negedge clk);
        w = 0;
        while (ready !== 1'b1 && w < 1000) begin @(negedge clk); w++; end
        check("ready_idle", ready, 1);
        dev_addr = d; reg_addr = r; data = x; start = 1'b1;
        t0 = cyc; s0 = n_starts; p0 = n_stops;
        @(negedge clk);
        if (!hold) start = 1'b0;
        check("busy_after_accept", ready, 0);
        check("err_cleared", ack_err, 0);
        wait_done(w);
        check("latency", cyc - t0, exp_lat);
        check("ack_err", ack_err, (nack < 3));
        check("ready_at_done", ready, 1);
        check("bus_released", {sda_oe, scl_oe}, 0);
        check("byte_count", rx_q.size(), nb);
        for (int i = 0; i < nb && i < rx_q.size(); i++)
            check($sformatf("byte%0d", i), rx_q[i], exp_b[i]);
        check("one_start", n_starts - s0, 1);
        check("stop_seen", n_stops - p0, 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        if (hold) begin
            check("no_accept_in_done", ready, 1);
            check("err_held", ack_err, (nack < 3));
            t0 = cyc;
            @(negedge clk);
            start = 1'b0;
            check("reaccept", ready, 0);
            check("err_clear_reaccept", ack_err, 0);
            wait_done(w);
            check("latency2", cyc - t0, exp_lat);
            check("ack_err2", ack_err, (nack < 3));
            @(negedge clk);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached, got %0d checks, expected completion", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int w, bad;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_ack_err", ack_err, 0);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_scl_oe", scl_oe, 0);
        reset_n = 1'b1;

        run_xfer(8'h72, 8'h98, 8'h03, 3, -1, -1, 0, 1'b0);
        run_xfer(8'h72, 8'h98, 8'h03, 1, -1, -1, 0, 1'b0);
        run_xfer(8'h73, 8'h5A, 8'hC3, 3, -1, -1, 0, 1'b0);
        run_xfer(8'h72, 8'h98, 8'h03, 3, 1, 3, 10, 1'b0);
        run_xfer(8'h72, 8'h11, 8'h22, 0, -1, -1, 0, 1'b1);

        // Reset in the ACK slot of the device byte.
        cfg_nack = 3; cfg_st_byte = -1; cfg_st_bit = -1; cfg_st_len = 0;
        @(negedge clk);
        dev_addr = 8'h72; reg_addr = 8'h98; data = 8'h03; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (sl_pull !== 1'b1 && w < 1000) begin @(negedge clk); w++; end
        check("reached_ack0", sl_pull, 1);
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_sda_oe", sda_oe, 0);
        check("midrst_scl_oe", scl_oe, 0);
        check("midrst_ready", ready, 1);
        check("midrst_done", done, 0);
        check("midrst_ack_err", ack_err, 0);
        reset_n = 1'b1;
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (done || sda_oe || scl_oe) bad++;
        end
        check("no_spurious_activity", bad, 0);

        for (int k = 0; k < 12; k++) begin
            logic [7:0] rd, rr, rx;
            int nk, nbk, sb, sbit, sl;
            rd = 8'($urandom); rr = 8'($urandom); rx = 8'($urandom);
            nk = int'($urandom_range(0, 5));
            if (nk > 3) nk = 3;
            nbk = (nk < 3) ? nk + 1 : 3;
            if ($urandom_range(0, 1) == 1) begin
                sb   = int'($urandom_range(0, nbk - 1));
                sbit = int'($urandom_range(0, 8));
                sl   = int'($urandom_range(1, 15));
            end else begin
                sb = -1; sbit = -1; sl = 0;
            end
            run_xfer(rd, rr, rx, nk, sb, sbit, sl, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
